bcd_converter_seq: RTL and testbench
====================================

// Module: bcd_converter_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.
//  Parametrised in binary width and decimal digit count.
//  Start/done handshake; overflow flag; optional leading-zero blanking mask.
//  Sits between the vending-machine credit/price registers and the seven-segment display driver.
// PARAMETERS
//  BIN_W   12  binary input width, 1..32
//  DIGITS  4   BCD output digits, 1..10; result digit i = bcd[4*i+3:4*i], i=0 is ones
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous, active-low reset
//  start     in   1          request conversion; honoured only when busy=0
//  binary    in   BIN_W      operand, sampled on the accepting edge only
//  busy      out  1          conversion in progress
//  done      out  1          one-cycle pulse: bcd/overflow just updated
//  bcd       out  4*DIGITS   packed BCD result, held until next done
//  overflow  out  1          binary >= 10**DIGITS for last result, held with bcd
//  blank     out  DIGITS     (BCD_BLANK_EN only) 1 = digit is a leading zero
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; busy=0, done=0, bcd=0, overflow=0, blank=0;
//    internal shift/scratch registers and counter cleared.
//  - FSM IDLE -> SHIFT -> IDLE:
//      IDLE: start=1 at edge E0 -> load shift reg=binary, scratch=0, cnt=0, ovf_acc=0; go to SHIFT, busy=1.
//      SHIFT: each edge: every scratch digit >=5 gets +3, then {scratch,shift} shifts left 1;
//             a 1 leaving the top scratch digit sets ovf_acc (sticky); cnt++.
//             On the BIN_W-th shift edge (E0+BIN_W): bcd<=final scratch, overflow<=final ovf_acc,
//             done<=1, busy<=0, state<=IDLE.
//  - Latency: done is high in the cycle after edge E0+BIN_W, i.e. BIN_W cycles after the accept edge.
//    Throughput: one conversion per BIN_W+1 cycles.
//  - done is high for exactly one cycle; state is IDLE in that cycle,
//    so start=1 during done is accepted (back-to-back).
//  - start while busy=1: ignored, no queueing; binary changes while busy have no effect.
//  - Overflow: bcd = value mod 10**DIGITS (truncated high digits), overflow=1.
//    Cannot occur when 2**BIN_W-1 < 10**DIGITS.
//  - bcd, overflow, blank change only on the done edge or on reset; stable while busy.
//  - Reset mid-conversion: conversion aborted; all outputs to reset values; no done pulse.
//  - Counter width: clog2(BIN_W+1); no other arithmetic wider than 4 bits per digit.
// CONFIGURATION
//  BCD_BLANK_EN defined:
//    - blank port present, registered with bcd on the done edge.
//    - blank[i]=1 iff digit i and all higher digits are 0, for i>=1; blank[0] always 0.
//    - Example: value 0 -> blank = all ones except bit 0.
//  BCD_BLANK_EN undefined: blank port and its logic are absent; all other behaviour identical.
// TESTING
//  1. BIN_W=12, DIGITS=4: reset, start with binary=4095 -> done 12 cycles after accept,
//     bcd=16'h4095, overflow=0.
//  2. binary=0 -> bcd=16'h0000; binary=999 -> bcd=16'h0999; with BCD_BLANK_EN: blank=4'b1110, then 4'b1000.
//  3. BIN_W=14, DIGITS=4: binary=12345 -> bcd=16'h2345, overflow=1; then binary=9999 -> 16'h9999, overflow=0.
//  4. Pulse start again at 3 cycles after accept with binary=7 -> ignored;
//     result is the first operand, single done pulse.
//  5. Hold start=1 with binary=1234 then 567 on done cycle -> two results 16'h1234, 16'h0567,
//     done pulses 13 cycles apart.
//  6. Assert rst_n=0 mid-conversion (cycle 5) -> busy=0, bcd=0, no done;
//     after release, new start converts correctly.
//  Full sweep 0..4095 against a reference model (x/10**i %10) in BIN_W=12 config; no mismatches.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double dabble), one binary bit per clock.
// Define BCD_BLANK_EN to add the registered leading-zero blanking mask output.
//
// state   | meaning
// S_IDLE  | waiting for start; last result held on bcd/overflow
// S_SHIFT | add-3 / shift-left once per clock, BIN_W clocks in total
module bcd_converter_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     scratch_nxt;
    logic [CW-1:0]     cnt;
    logic              ovf_acc;
    logic              ovf_nxt;
    logic              load;
    logic              step;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == CW'(BIN_W - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SHIFT);
        load = (state == S_IDLE) && start;
        step = (state == S_SHIFT);
        last = (state == S_SHIFT) && (cnt == CW'(BIN_W - 1));
    end

    // Digit correction happens before the shift; a carry out of the top digit
    // means the value no longer fits in DIGITS decimal digits.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        scratch_nxt = {adj[SW-2:0], shift_q[BIN_W-1]};
        ovf_nxt     = ovf_acc | adj[SW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
        end else if (load) begin
            shift_q   <= binary;
            scratch_q <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
        end else if (step) begin
            shift_q   <= shift_q << 1;
            scratch_q <= scratch_nxt;
            cnt       <= cnt + CW'(1);
            ovf_acc   <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                bcd      <= scratch_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Digit 0 is never blanked so that a value of zero still shows one "0".
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (scratch_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (last) begin
            blank <= blank_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq: 12-bit and 14-bit instances, 4 digits each.
// Blank-mask checks are compiled in when BCD_BLANK_EN is defined.
module tb_bcd_converter_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start12 = 1'b0;
    logic        start14 = 1'b0;
    logic [11:0] bin12 = '0;
    logic [13:0] bin14 = '0;
    logic        busy12, done12, ovf12;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd12, bcd14;
`ifdef BCD_BLANK_EN
    logic [3:0]  blank12, blank14;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_done12 = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (done12) n_done12++;
    end

    bcd_converter_seq #(.BIN_W(12), .DIGITS(4)) u12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .binary(bin12),
        .busy(busy12), .done(done12), .bcd(bcd12), .overflow(ovf12)
`ifdef BCD_BLANK_EN
        , .blank(blank12)
`endif
    );

    bcd_converter_seq #(.BIN_W(14), .DIGITS(4)) u14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .binary(bin14),
        .busy(busy14), .done(done14), .bcd(bcd14), .overflow(ovf14)
`ifdef BCD_BLANK_EN
        , .blank(blank14)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int x);
        int m;
        logic [15:0] r;
        m = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((x / m) % 10);
            m = m * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_blank(input int x);
        int t;
        logic [3:0] r;
        t = x % 10000;
        r = '0;
        r[1] = (t < 10);
        r[2] = (t < 100);
        r[3] = (t < 1000);
        return r;
    endfunction

    // Starts one conversion and returns at the negedge where done is high
    // (or after a 40-cycle bound); lat counts posedges after the accept edge.
    task automatic convert(input int sel, input int value, output int lat);
        @(negedge clk);
        if (sel == 0) begin
            start12 = 1'b1; bin12 = 12'(value);
        end else begin
            start14 = 1'b1; bin14 = 14'(value);
        end
        @(posedge clk);
        #1;
        start12 = 1'b0;
        start14 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel == 0) ? done12 : done14) break;
        end
    endtask

    initial begin
        int lat, d0, t1, t2;

        // reset values
        #12;
        chk("rst_busy12", busy12, 0);
        chk("rst_done12", done12, 0);
        chk("rst_bcd12", bcd12, 0);
        chk("rst_ovf12", ovf12, 0);
        chk("rst_bcd14", bcd14, 0);
`ifdef BCD_BLANK_EN
        chk("rst_blank12", blank12, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 1: max 12-bit operand, latency 12
        convert(0, 4095, lat);
        chk("t1_lat", lat, 12);
        chk("t1_bcd", bcd12, 16'h4095);
        chk("t1_ovf", ovf12, 0);
        chk("t1_busy_at_done", busy12, 0);
        @(negedge clk);
        chk("t1_done_one_cycle", done12, 0);

        // 2: zero and 999
        convert(0, 0, lat);
        chk("t2_bcd0", bcd12, 16'h0000);
`ifdef BCD_BLANK_EN
        chk("t2_blank0", blank12, 4'b1110);
`endif
        convert(0, 999, lat);
        chk("t2_bcd999", bcd12, 16'h0999);
`ifdef BCD_BLANK_EN
        chk("t2_blank999", blank12, 4'b1000);
`endif

        // 3: 14-bit operand with and without overflow
        convert(1, 12345, lat);
        chk("t3_lat", lat, 14);
        chk("t3_bcd", bcd14, 16'h2345);
        chk("t3_ovf", ovf14, 1);
`ifdef BCD_BLANK_EN
        chk("t3_blank", blank14, 4'b0000);
`endif
        convert(1, 9999, lat);
        chk("t3_bcd9999", bcd14, 16'h9999);
        chk("t3_ovf9999", ovf14, 0);
        convert(1, 16383, lat);
        chk("t3_bcd16383", bcd14, 16'h6383);
        chk("t3_ovf16383", ovf14, 1);
        convert(1, 10000, lat);
        chk("t3_bcd10000", bcd14, 16'h0000);
        chk("t3_ovf10000", ovf14, 1);

        // 4: start while busy is ignored
        d0 = n_done12;
        @(negedge clk);
        start12 = 1'b1; bin12 = 12'd321;
        @(posedge clk);
        #1 start12 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t4_busy", busy12, 1);
        chk("t4_bcd_held", bcd12, 16'h0999);
        start12 = 1'b1; bin12 = 12'd7;
        @(posedge clk);
        #1 start12 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done12) break;
            lat++;
        end
        chk("t4_bcd", bcd12, 16'h0321);
        repeat (20) @(negedge clk);
        chk("t4_single_done", n_done12 - d0, 1);
        chk("t4_bcd_after", bcd12, 16'h0321);
        chk("t4_idle", busy12, 0);

        // 5: start held high, back-to-back conversions
        @(negedge clk);
        start12 = 1'b1; bin12 = 12'd1234;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done12) break;
            lat++;
        end
        t1 = cyc;
        chk("t5_bcd1", bcd12, 16'h1234);
        bin12 = 12'd567;
        @(posedge clk);
        #1 start12 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done12) break;
            lat++;
        end
        t2 = cyc;
        chk("t5_bcd2", bcd12, 16'h0567);
        chk("t5_spacing", t2 - t1, 13);

        // 6: reset mid-conversion
        @(negedge clk);
        start12 = 1'b1; bin12 = 12'd888;
        @(posedge clk);
        #1 start12 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        d0 = n_done12;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy12, 0);
        chk("t6_bcd", bcd12, 0);
        chk("t6_ovf", ovf12, 0);
        chk("t6_done", done12, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_done", n_done12 - d0, 0);
        convert(0, 42, lat);
        chk("t6_lat", lat, 12);
        chk("t6_bcd_after", bcd12, 16'h0042);

        // full 12-bit sweep against the decimal model
        for (int v = 0; v < 4096; v++) begin
            convert(0, v, lat);
            chk("sweep_bcd", bcd12, ref_bcd(v));
            chk("sweep_ovf", ovf12, 0);
`ifdef BCD_BLANK_EN
            chk("sweep_blank", blank12, ref_blank(v));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
